// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types for the 5-stage core pipeline sequencer.
//               Holds the sequencer state enum, the bundle of per-stage
//               enables and flushes, canned control patterns, and the
//               priority resolver used in the RUN state.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN           = 3'd0,
    DMEM_WAIT     = 3'd1,
    MDU_WAIT      = 3'd2,
    TRAP_DRAIN    = 3'd3,
    TRAP_REDIRECT = 3'd4
  } pipe_state_t;

  // Field order fixes the packed bit order: pc_en is the MSB,
  // exe_mem_flush the LSB.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_exe_flush;
    logic exe_mem_flush;
  } stage_ctrl_t;

  typedef struct packed {
    stage_ctrl_t ctrl;
    pipe_state_t nxt;
  } run_dec_t;

  // Normal flow: everything advances, nothing flushed.
  localparam stage_ctrl_t c_ctrl_flow     = stage_ctrl_t'(8'b1111_1000);
  // Full freeze of every pipeline register.
  localparam stage_ctrl_t c_ctrl_hold     = stage_ctrl_t'(8'b0000_0000);
  // Taken branch: advance and squash the three younger stages.
  localparam stage_ctrl_t c_ctrl_branch   = stage_ctrl_t'(8'b1111_1111);
  // MDU busy: freeze front end, bubble into EXE/MEM, let MEM/WB drain.
  localparam stage_ctrl_t c_ctrl_mdu      = stage_ctrl_t'(8'b0011_1001);
  // MDU result ready: capture it into EXE/MEM, front end still frozen.
  localparam stage_ctrl_t c_ctrl_mdu_done = stage_ctrl_t'(8'b0011_1000);
  // Load-use: hold PC and IF/ID, bubble into ID/EXE.
  localparam stage_ctrl_t c_ctrl_load     = stage_ctrl_t'(8'b0011_1010);
  // Fetch miss: hold PC, bubble into IF/ID.
  localparam stage_ctrl_t c_ctrl_imiss    = stage_ctrl_t'(8'b0111_1100);
  // Trap redirect: PC takes the vector, younger stages squashed and the
  // faulting MEM instruction is kept out of WB.
  localparam stage_ctrl_t c_ctrl_redirect = stage_ctrl_t'(8'b1111_0111);

  // Priority resolver for a cycle spent in RUN. i_dmem_busy is passed in
  // separately so that the DMEM_WAIT ack cycle can reuse it with the data
  // access already treated as complete.
  function automatic run_dec_t run_decide(
    input logic i_dmem_busy,
    input logic i_trap_req,
    input logic i_branch_hazard,
    input logic i_mdu_start,
    input logic i_load_hazard,
    input logic i_imem_ack
  );
    run_dec_t d;
    d.ctrl = c_ctrl_flow;
    d.nxt  = RUN;
    if (i_dmem_busy) begin
      d.ctrl = c_ctrl_hold;
      d.nxt  = DMEM_WAIT;
    end else if (i_trap_req) begin
      d.ctrl = c_ctrl_hold;
      d.nxt  = TRAP_DRAIN;
    end else if (i_branch_hazard) begin
      // A load hazard in the same cycle is moot: its consumer is squashed.
      d.ctrl = c_ctrl_branch;
    end else if (i_mdu_start) begin
      d.ctrl = c_ctrl_mdu;
      d.nxt  = MDU_WAIT;
    end else if (i_load_hazard) begin
      d.ctrl = c_ctrl_load;
    end else if (!i_imem_ack) begin
      d.ctrl = c_ctrl_imiss;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Handshake bundle between the core datapath and the pipeline
//               sequencer.
// Modports    : master - core side: drives hazard/handshake/trap inputs,
//                        receives enables, flushes, trap pulse and status.
//               slave  - sequencer side (pipeline_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  // Core -> sequencer
  logic load_hazard;
  logic branch_hazard;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic mdu_start;
  logic mdu_done;
  logic trap_req;
  logic cnt_clr;
  // Sequencer -> core
  logic pc_en;
  logic if_id_en;
  logic id_exe_en;
  logic exe_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_exe_flush;
  logic exe_mem_flush;
  logic trap_redirect;
  logic trap_ack;
  logic mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output load_hazard, branch_hazard, imem_ack, dmem_req, dmem_ack,
           mdu_start, mdu_done, trap_req, cnt_clr,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush,
           trap_redirect, trap_ack, mdu_timeout, stall_cnt
  );

  modport slave (
    input  load_hazard, branch_hazard, imem_ack, dmem_req, dmem_ack,
           mdu_start, mdu_done, trap_req, cnt_clr,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
           if_id_flush, id_exe_flush, exe_mem_flush,
           trap_redirect, trap_ack, mdu_timeout, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : stall_counter
// Description : Generic wrapping event counter for performance CSRs.
//               Clear has priority over increment.
// Ports       : clk     - clock
//               reset_n - synchronous active-low reset
//               i_inc   - count this cycle
//               i_clr   - zero the counter on the next edge
//               o_cnt   - current count
// Revision    : 1.0 - initial release
// ============================================================================
module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 5-stage core. Resolves memory
//               waits, MDU waits, hazards and traps into per-stage register
//               enables/flushes, PC enable and a trap redirect pulse, and
//               counts stalled cycles.
// Ports       : clk     - core clock
//               reset_n - synchronous active-low reset
//               bus     - pipeline_ctrl_if.slave (hazard/handshake inputs,
//                         stage controls, trap pulse, status, stall count)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_MAX_CYC = 34
) (
  input  logic           clk,
  input  logic           reset_n,
  pipeline_ctrl_if.slave bus
);

  localparam int c_mdu_w = (MDU_MAX_CYC > 1) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [c_mdu_w-1:0] c_mdu_last = c_mdu_w'(MDU_MAX_CYC - 1);

  pipe_state_t          r_state;
  logic [c_mdu_w-1:0]   r_mdu_cyc;
  logic                 r_mdu_timeout;

  pipe_state_t          w_nxt;
  stage_ctrl_t          w_ctrl;
  logic                 w_trap_pulse;
  logic                 w_mdu_expire;
  logic                 w_dmem_busy;
  run_dec_t             w_run;
  run_dec_t             w_run_acked;

  assign w_dmem_busy = bus.dmem_req & ~bus.dmem_ack;

  always_comb begin
    w_run = run_decide(w_dmem_busy, bus.trap_req, bus.branch_hazard,
                       bus.mdu_start, bus.load_hazard, bus.imem_ack);
    // Same rules on the DMEM_WAIT ack cycle, data access counted as done.
    w_run_acked = run_decide(1'b0, bus.trap_req, bus.branch_hazard,
                             bus.mdu_start, bus.load_hazard, bus.imem_ack);
  end

  always_comb begin
    w_ctrl       = c_ctrl_flow;
    w_nxt        = r_state;
    w_trap_pulse = 1'b0;
    w_mdu_expire = 1'b0;
    case (r_state)
      RUN: begin
        w_ctrl = w_run.ctrl;
        w_nxt  = w_run.nxt;
      end
      DMEM_WAIT: begin
        if (bus.dmem_ack) begin
          w_ctrl = w_run_acked.ctrl;
          w_nxt  = w_run_acked.nxt;
        end else begin
          w_ctrl = c_ctrl_hold;
        end
      end
      MDU_WAIT: begin
        // A result arriving on the limit cycle is still accepted.
        if (bus.mdu_done) begin
          w_ctrl = c_ctrl_mdu_done;
          w_nxt  = RUN;
        end else begin
          w_ctrl = c_ctrl_mdu;
          if (r_mdu_cyc == c_mdu_last) begin
            w_mdu_expire = 1'b1;
            w_nxt        = RUN;
          end
        end
      end
      TRAP_DRAIN: begin
        w_ctrl = c_ctrl_hold;
        if (!w_dmem_busy) begin
          w_nxt = TRAP_REDIRECT;
        end
      end
      TRAP_REDIRECT: begin
        w_ctrl       = c_ctrl_redirect;
        w_trap_pulse = 1'b1;
        w_nxt        = RUN;
      end
      default: begin
        w_nxt = RUN;
      end
    endcase
    // While reset is asserted the pending trap is being aborted, so no
    // redirect or acknowledge may leak out of a TRAP_REDIRECT state.
    if (!reset_n) begin
      w_ctrl       = c_ctrl_flow;
      w_trap_pulse = 1'b0;
      w_mdu_expire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_mdu_cyc     <= '0;
      r_mdu_timeout <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // Counts cycles already spent in MDU_WAIT; restarts on every entry.
      if (r_state != MDU_WAIT) begin
        r_mdu_cyc <= '0;
      end else begin
        r_mdu_cyc <= r_mdu_cyc + c_mdu_w'(1);
      end
      if (w_mdu_expire) begin
        r_mdu_timeout <= 1'b1;
      end
    end
  end

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (~w_ctrl.pc_en),
    .i_clr   (bus.cnt_clr),
    .o_cnt   (bus.stall_cnt)
  );

  assign bus.pc_en         = w_ctrl.pc_en;
  assign bus.if_id_en      = w_ctrl.if_id_en;
  assign bus.id_exe_en     = w_ctrl.id_exe_en;
  assign bus.exe_mem_en    = w_ctrl.exe_mem_en;
  assign bus.mem_wb_en     = w_ctrl.mem_wb_en;
  assign bus.if_id_flush   = w_ctrl.if_id_flush;
  assign bus.id_exe_flush  = w_ctrl.id_exe_flush;
  assign bus.exe_mem_flush = w_ctrl.exe_mem_flush;
  assign bus.trap_redirect = w_trap_pulse;
  assign bus.trap_ack      = w_trap_pulse;
  assign bus.mdu_timeout   = r_mdu_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl: directed scenarios
//               plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int CNT_W       = 32;
  localparam int MDU_MAX_CYC = 34;

  // Expected control vectors, bit order {pc, if_id, id_exe, exe_mem, mem_wb,
  // if_id_flush, id_exe_flush, exe_mem_flush}.
  localparam logic [7:0] E_FLOW   = 8'b1111_1000;
  localparam logic [7:0] E_HOLD   = 8'b0000_0000;
  localparam logic [7:0] E_BRANCH = 8'b1111_1111;
  localparam logic [7:0] E_MDU    = 8'b0011_1001;
  localparam logic [7:0] E_MDUOK  = 8'b0011_1000;
  localparam logic [7:0] E_LOAD   = 8'b0011_1010;
  localparam logic [7:0] E_IMISS  = 8'b0111_1100;
  localparam logic [7:0] E_TRAP   = 8'b1111_0111;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .CNT_W       (CNT_W),
    .MDU_MAX_CYC (MDU_MAX_CYC)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.pc_en, bus.if_id_en, bus.id_exe_en, bus.exe_mem_en,
            bus.mem_wb_en, bus.if_id_flush, bus.id_exe_flush,
            bus.exe_mem_flush};
  endfunction

  // ---------------- behavioural reference model ----------------
  // phase: 0 running, 1 waiting on data memory, 2 waiting on MDU,
  //        3 draining for trap, 4 redirecting to trap vector
  int          m_phase;
  int          m_age;
  logic        m_timeout;
  logic [31:0] m_stall;

  function automatic logic [7:0] run_rules(input bit busy, output int nxt);
    nxt = 0;
    if (busy) begin nxt = 1; return E_HOLD; end
    if (bus.trap_req) begin nxt = 3; return E_HOLD; end
    if (bus.branch_hazard) return E_BRANCH;
    if (bus.mdu_start) begin nxt = 2; return E_MDU; end
    if (bus.load_hazard) return E_LOAD;
    if (!bus.imem_ack) return E_IMISS;
    return E_FLOW;
  endfunction

  function automatic void model_eval(output logic [7:0] ctl, output bit pulse,
                                     output int nxt, output bit expire);
    bit busy;
    busy   = bus.dmem_req && !bus.dmem_ack;
    pulse  = 0;
    expire = 0;
    nxt    = m_phase;
    ctl    = E_FLOW;
    case (m_phase)
      0: ctl = run_rules(busy, nxt);
      1: if (bus.dmem_ack) ctl = run_rules(1'b0, nxt); else ctl = E_HOLD;
      2: begin
        if (bus.mdu_done) begin
          ctl = E_MDUOK; nxt = 0;
        end else begin
          ctl = E_MDU;
          if (m_age + 1 >= MDU_MAX_CYC) begin expire = 1; nxt = 0; end
        end
      end
      3: begin ctl = E_HOLD; nxt = busy ? 3 : 4; end
      default: begin ctl = E_TRAP; pulse = 1; nxt = 0; end
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] c;
    bit p, e;
    int n;
    if (!reset_n) begin
      m_phase = 0; m_age = 0; m_timeout = 0; m_stall = '0;
    end else begin
      model_eval(c, p, n, e);
      if (bus.cnt_clr) m_stall = '0;
      else if (!c[7]) m_stall = m_stall + 32'd1;
      if (e) m_timeout = 1;
      if (m_phase != 2) m_age = 0; else m_age = m_age + 1;
      m_phase = n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.load_hazard = 0; bus.branch_hazard = 0; bus.imem_ack = 1;
    bus.dmem_req = 0; bus.dmem_ack = 0; bus.mdu_start = 0;
    bus.mdu_done = 0; bus.trap_req = 0; bus.cnt_clr = 0;
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  function automatic logic chance(input int pct);
    return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({outs(), bus.trap_redirect, bus.trap_ack} !== {E_FLOW, 2'b00}) begin
      $display("FAIL reset_ctrl got=%b exp=%b", {outs(), bus.trap_redirect, bus.trap_ack}, {E_FLOW, 2'b00});
    end else n_pass++;
    n_checks++;
    if ({bus.stall_cnt, bus.mdu_timeout} !== {32'd0, 1'b0}) begin
      $display("FAIL reset_status cnt=%0d to=%b exp cnt=0 to=0", bus.stall_cnt, bus.mdu_timeout);
    end else n_pass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    bus.load_hazard = 1;
    #1;
    n_checks++;
    if (outs() !== E_LOAD) $display("FAIL load_use_ctrl got=%b exp=%b", outs(), E_LOAD);
    else n_pass++;
    tick();
    bus.load_hazard = 0;
    #1;
    n_checks++;
    if (outs() !== E_FLOW) $display("FAIL load_use_release got=%b exp=%b", outs(), E_FLOW);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'd1) $display("FAIL load_use_cnt got=%0d exp=1", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch_load();
    apply_reset();
    bus.branch_hazard = 1;
    bus.load_hazard   = 1;
    #1;
    n_checks++;
    if (outs() !== E_BRANCH) $display("FAIL branch_load_ctrl got=%b exp=%b", outs(), E_BRANCH);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL branch_load_cnt got=%0d exp=0", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_imem_miss();
    apply_reset();
    bus.imem_ack = 0;
    #1;
    n_checks++;
    if (outs() !== E_IMISS) $display("FAIL imem_miss_ctrl got=%b exp=%b", outs(), E_IMISS);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_dmem_wait();
    apply_reset();
    bus.dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (outs() !== E_HOLD) $display("FAIL dmem_wait_hold[%0d] got=%b exp=%b", i, outs(), E_HOLD);
      else n_pass++;
      tick();
    end
    bus.dmem_ack = 1;
    #1;
    n_checks++;
    if (outs() !== E_FLOW) $display("FAIL dmem_ack_ctrl got=%b exp=%b", outs(), E_FLOW);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'd3) $display("FAIL dmem_wait_cnt got=%0d exp=3", bus.stall_cnt);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (outs() !== E_FLOW || bus.stall_cnt !== 32'd3)
      $display("FAIL dmem_after got=%b/%0d exp=%b/3", outs(), bus.stall_cnt, E_FLOW);
    else n_pass++;
  endtask

  task automatic test_mdu_done();
    apply_reset();
    bus.mdu_start = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (outs() !== E_MDU) $display("FAIL mdu_busy[%0d] got=%b exp=%b", i, outs(), E_MDU);
      else n_pass++;
      tick();
      bus.mdu_start = 0;
    end
    bus.mdu_done = 1;
    #1;
    n_checks++;
    if (outs() !== E_MDUOK) $display("FAIL mdu_done_ctrl got=%b exp=%b", outs(), E_MDUOK);
    else n_pass++;
    tick();
    bus.mdu_done = 0;
    #1;
    n_checks++;
    if ({outs(), bus.mdu_timeout, bus.stall_cnt} !== {E_FLOW, 1'b0, 32'd11})
      $display("FAIL mdu_done_after got=%b/%b/%0d exp=%b/0/11", outs(), bus.mdu_timeout, bus.stall_cnt, E_FLOW);
    else n_pass++;
  endtask

  task automatic test_mdu_timeout();
    apply_reset();
    bus.mdu_start = 1;
    tick();
    bus.mdu_start = 0;
    for (int i = 0; i < MDU_MAX_CYC; i++) begin
      #1;
      n_checks++;
      if ({outs(), bus.mdu_timeout} !== {E_MDU, 1'b0})
        $display("FAIL mdu_wait[%0d] got=%b/%b exp=%b/0", i, outs(), bus.mdu_timeout, E_MDU);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if ({outs(), bus.mdu_timeout} !== {E_FLOW, 1'b1})
      $display("FAIL mdu_timeout got=%b/%b exp=%b/1", outs(), bus.mdu_timeout, E_FLOW);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 32'd35) $display("FAIL mdu_timeout_cnt got=%0d exp=35", bus.stall_cnt);
    else n_pass++;
    // Sticky: a later clean MDU operation does not clear the flag.
    bus.mdu_start = 1;
    tick();
    bus.mdu_start = 0;
    bus.mdu_done  = 1;
    tick();
    bus.mdu_done  = 0;
    #1;
    n_checks++;
    if (bus.mdu_timeout !== 1'b1) $display("FAIL mdu_timeout_sticky got=%b exp=1", bus.mdu_timeout);
    else n_pass++;
  endtask

  task automatic test_trap_dmem();
    apply_reset();
    bus.dmem_req = 1;
    tick();
    bus.trap_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({outs(), bus.trap_ack} !== {E_HOLD, 1'b0})
        $display("FAIL trap_deferred[%0d] got=%b exp=%b", i, {outs(), bus.trap_ack}, {E_HOLD, 1'b0});
      else n_pass++;
      tick();
    end
    bus.dmem_ack = 1;
    #1;
    n_checks++;
    if ({outs(), bus.trap_ack} !== {E_HOLD, 1'b0})
      $display("FAIL trap_ack_cycle got=%b exp=%b", {outs(), bus.trap_ack}, {E_HOLD, 1'b0});
    else n_pass++;
    tick();
    bus.dmem_req = 0;
    bus.dmem_ack = 0;
    #1;
    n_checks++;
    if ({outs(), bus.trap_ack} !== {E_HOLD, 1'b0})
      $display("FAIL trap_drain got=%b exp=%b", {outs(), bus.trap_ack}, {E_HOLD, 1'b0});
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({outs(), bus.trap_redirect, bus.trap_ack} !== {E_TRAP, 2'b11})
      $display("FAIL trap_redirect got=%b exp=%b", {outs(), bus.trap_redirect, bus.trap_ack}, {E_TRAP, 2'b11});
    else n_pass++;
    tick();
    bus.trap_req = 0;
    #1;
    n_checks++;
    if ({outs(), bus.trap_redirect, bus.trap_ack} !== {E_FLOW, 2'b00})
      $display("FAIL trap_single_pulse got=%b exp=%b", {outs(), bus.trap_redirect, bus.trap_ack}, {E_FLOW, 2'b00});
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    apply_reset();
    bus.mdu_start = 1;
    tick();
    bus.mdu_start = 0;
    tick(); tick(); tick();
    reset_n = 0;
    #1;
    n_checks++;
    if (bus.trap_ack !== 1'b0) $display("FAIL reset_mdu_ack got=%b exp=0", bus.trap_ack);
    else n_pass++;
    tick();
    reset_n = 1;
    #1;
    n_checks++;
    if ({outs(), bus.stall_cnt, bus.mdu_timeout} !== {E_FLOW, 32'd0, 1'b0})
      $display("FAIL reset_mdu_state got=%b/%0d/%b exp=%b/0/0", outs(), bus.stall_cnt, bus.mdu_timeout, E_FLOW);
    else n_pass++;
    // Reset arriving in the redirect cycle suppresses the acknowledge.
    bus.trap_req = 1;
    tick(); tick();
    reset_n = 0;
    #1;
    n_checks++;
    if ({bus.trap_redirect, bus.trap_ack} !== 2'b00)
      $display("FAIL reset_trap_ack got=%b exp=00", {bus.trap_redirect, bus.trap_ack});
    else n_pass++;
    tick();
    reset_n = 1;
    bus.trap_req = 0;
  endtask

  task automatic test_cnt_clr();
    apply_reset();
    bus.load_hazard = 1;
    tick(); tick();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 32'd2) $display("FAIL cnt_before_clr got=%0d exp=2", bus.stall_cnt);
    else n_pass++;
    bus.cnt_clr = 1;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL cnt_clr got=%0d exp=0", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] e_ctl;
    bit e_pulse, e_exp;
    int e_nxt;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bus.load_hazard   = chance(20);
      bus.branch_hazard = chance(10);
      bus.imem_ack      = chance(80);
      bus.dmem_req      = chance(30);
      bus.dmem_ack      = chance(50);
      bus.mdu_start     = chance(6);
      bus.mdu_done      = chance(15);
      bus.cnt_clr       = chance(2);
      if (!bus.trap_req) bus.trap_req = chance(4);
      #1;
      model_eval(e_ctl, e_pulse, e_nxt, e_exp);
      n_checks++;
      if ({outs(), bus.trap_redirect, bus.trap_ack, bus.mdu_timeout} !== {e_ctl, e_pulse, e_pulse, m_timeout})
        $display("FAIL random_ctrl[%0d] got=%b exp=%b", i,
                 {outs(), bus.trap_redirect, bus.trap_ack, bus.mdu_timeout}, {e_ctl, e_pulse, e_pulse, m_timeout});
      else n_pass++;
      n_checks++;
      if (bus.stall_cnt !== m_stall)
        $display("FAIL random_cnt[%0d] got=%0d exp=%0d", i, bus.stall_cnt, m_stall);
      else n_pass++;
      tick();
      if (e_pulse) bus.trap_req = 0;
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_load();
    test_imem_miss();
    test_dmem_wait();
    test_mdu_done();
    test_mdu_timeout();
    test_trap_dmem();
    test_reset_abort();
    test_cnt_clr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
